// File: rtl/clock_switch_ctrl.sv
// Select/sequence controller for the glitch-free clka/clkb switch.
// Watches both clocks from the reference domain and fails over on loss.

module clock_switch_mon #(
  parameter int SYNC_STAGES = 2,
  parameter int LOSS_WIN    = 16,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic tgl,
  output logic ok
);

  localparam logic [CNT_W-1:0] LW = CNT_W'(LOSS_WIN);

  // sh[SYNC_STAGES-1] is the last sync stage, sh[SYNC_STAGES] the history flop
  logic [SYNC_STAGES:0] sh;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_nxt;
  logic                 edge_det;

  assign edge_det = sh[SYNC_STAGES] ^ sh[SYNC_STAGES-1];

  always_comb begin
    cnt_nxt = cnt;
    if (edge_det)
      cnt_nxt = '0;
    else if (cnt < LW)
      cnt_nxt = cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh  <= '0;
      cnt <= LW;
      ok  <= 1'b0;
    end else begin
      sh  <= {sh[SYNC_STAGES-1:0], tgl};
      cnt <= cnt_nxt;
      ok  <= (cnt_nxt < LW);
    end
  end

endmodule

module clock_switch_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int LOSS_WIN    = 16,
  parameter int SETTLE_CYC  = 64,
  parameter int HOLD_CYC    = 32,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clka_tgl,
  input  logic clkb_tgl,
  input  logic auto_en,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  output logic sel_clkb,
  output logic busy,
  output logic done,
  output logic err,
  output logic fail_irq,
  output logic clka_ok,
  output logic clkb_ok
);

  localparam logic [CNT_W-1:0] SC_M1 = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] HC_M1 =
    CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sel_nxt;
  logic             done_nxt;
  logic             err_nxt;
  logic             fail_nxt;
  logic             cur_ok;
  logic             oth_ok;
  logic             req_ok;
  logic             fail_cond;
  logic             accept;

  clock_switch_mon #(
    .SYNC_STAGES(SYNC_STAGES),
    .LOSS_WIN   (LOSS_WIN),
    .CNT_W      (CNT_W)
  ) u_mon_a (
    .clk(clk),
    .rst(rst),
    .tgl(clka_tgl),
    .ok (clka_ok)
  );

  clock_switch_mon #(
    .SYNC_STAGES(SYNC_STAGES),
    .LOSS_WIN   (LOSS_WIN),
    .CNT_W      (CNT_W)
  ) u_mon_b (
    .clk(clk),
    .rst(rst),
    .tgl(clkb_tgl),
    .ok (clkb_ok)
  );

  assign cur_ok    = sel_clkb ? clkb_ok : clka_ok;
  assign oth_ok    = sel_clkb ? clka_ok : clkb_ok;
  assign req_ok    = req_sel ? clkb_ok : clka_ok;
  assign fail_cond = auto_en && !cur_ok && oth_ok;
  assign req_ready = (state == IDLE) && !fail_cond;
  assign accept    = req_valid && req_ready;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = sel_clkb;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    fail_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (fail_cond) begin
          sel_nxt   = ~sel_clkb;
          fail_nxt  = 1'b1;
          cnt_nxt   = SC_M1;
          state_nxt = SETTLE;
        end else if (accept) begin
          if (req_sel == sel_clkb) begin
            done_nxt = 1'b1;
          end else if (!req_ok) begin
            err_nxt = 1'b1;
          end else begin
            sel_nxt   = req_sel;
            cnt_nxt   = SC_M1;
            state_nxt = SETTLE;
          end
        end
      end
      SETTLE: begin
        // losing the new source aborts; IDLE may then fail back over
        if (!cur_ok) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == '0) begin
          done_nxt = 1'b1;
          if (HOLD_CYC == 0) begin
            state_nxt = IDLE;
          end else begin
            cnt_nxt   = HC_M1;
            state_nxt = HOLD;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt == '0)
          state_nxt = IDLE;
        else
          cnt_nxt = cnt - CNT_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      sel_clkb <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      fail_irq <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      sel_clkb <= sel_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
      fail_irq <= fail_nxt;
    end
  end

endmodule

// File: tb/tb_clock_switch_ctrl.sv
// Bench for clock_switch_ctrl: directed scenarios plus random traffic
// against a timestamp-based reference model.

module tb_clock_switch_ctrl;

  localparam int SS = 2;
  localparam int LW = 16;
  localparam int SC = 64;
  localparam int HC = 32;
  localparam int CW = 8;
  localparam int NEVER = -1000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clka_tgl = 1'b0;
  logic clkb_tgl = 1'b0;
  logic auto_en = 1'b0;
  logic req_valid = 1'b0;
  logic req_sel = 1'b0;
  logic req_ready;
  logic sel_clkb;
  logic busy;
  logic done;
  logic err;
  logic fail_irq;
  logic clka_ok;
  logic clkb_ok;

  int total = 0;
  int bad = 0;

  clock_switch_ctrl #(
    .SYNC_STAGES(SS),
    .LOSS_WIN   (LW),
    .SETTLE_CYC (SC),
    .HOLD_CYC   (HC),
    .CNT_W      (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clka_tgl (clka_tgl),
    .clkb_tgl (clkb_tgl),
    .auto_en  (auto_en),
    .req_valid(req_valid),
    .req_sel  (req_sel),
    .req_ready(req_ready),
    .sel_clkb (sel_clkb),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .fail_irq (fail_irq),
    .clka_ok  (clka_ok),
    .clkb_ok  (clkb_ok)
  );

  always #5 clk = ~clk;

  // reference model: cycle stamps of last edge / last switch start
  int n;
  int last_a;
  int last_b;
  int sw_t;
  bit ha[SS+2];
  bit hb[SS+2];
  bit m_sel, m_done, m_err, m_fail, m_aok, m_bok, m_acc;
  bit a_run, b_run, pend, rq_en;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_idle(input int k);
    return k > sw_t + SC + HC;
  endfunction

  function automatic bit m_ready();
    bit cur, oth;
    cur = m_sel ? m_bok : m_aok;
    oth = m_sel ? m_aok : m_bok;
    return m_idle(n + 1) && !(auto_en && !cur && oth);
  endfunction

  task automatic m_reset();
    n = 0;
    sw_t = NEVER;
    last_a = NEVER;
    last_b = NEVER;
    m_sel = 0; m_done = 0; m_err = 0; m_fail = 0;
    m_aok = 0; m_bok = 0; m_acc = 0;
    for (int k = 0; k < SS + 2; k++) begin
      ha[k] = 0;
      hb[k] = 0;
    end
  endtask

  task automatic model_step();
    bit cur, oth, fc, tok;
    n++;
    m_done = 0; m_err = 0; m_fail = 0; m_acc = 0;
    cur = m_sel ? m_bok : m_aok;
    oth = m_sel ? m_aok : m_bok;
    fc  = auto_en && !cur && oth;
    tok = req_sel ? m_bok : m_aok;
    if (m_idle(n)) begin
      if (fc) begin
        m_sel = !m_sel;
        m_fail = 1;
        sw_t = n;
      end else if (req_valid) begin
        m_acc = 1;
        if (req_sel == m_sel) m_done = 1;
        else if (!tok) m_err = 1;
        else begin
          m_sel = req_sel;
          sw_t = n;
        end
      end
    end else if (n <= sw_t + SC) begin
      if (!cur) begin
        m_err = 1;
        sw_t = NEVER;
      end else if (n == sw_t + SC) begin
        m_done = 1;
      end
    end
    for (int k = SS + 1; k > 0; k--) begin
      ha[k] = ha[k-1];
      hb[k] = hb[k-1];
    end
    ha[0] = clka_tgl;
    hb[0] = clkb_tgl;
    if (ha[SS] != ha[SS+1]) last_a = n;
    if (hb[SS] != hb[SS+1]) last_b = n;
    m_aok = (n - last_a) < LW;
    m_bok = (n - last_b) < LW;
  endtask

  // called at a negedge after inputs are driven; returns at the next negedge
  task automatic step();
    #1 chk("req_ready", int'(req_ready), int'(m_ready()));
    @(posedge clk);
    if (rst) m_reset();
    else model_step();
    if (m_acc) pend = 0;
    @(negedge clk);
    chk("sel_clkb", int'(sel_clkb), int'(m_sel));
    chk("busy", int'(busy), int'(!m_idle(n + 1)));
    chk("done", int'(done), int'(m_done));
    chk("err", int'(err), int'(m_err));
    chk("fail_irq", int'(fail_irq), int'(m_fail));
    chk("clka_ok", int'(clka_ok), int'(m_aok));
    chk("clkb_ok", int'(clkb_ok), int'(m_bok));
  endtask

  task automatic drive();
    if (a_run && $urandom_range(0, 1) == 1) clka_tgl = ~clka_tgl;
    if (b_run && $urandom_range(0, 1) == 1) clkb_tgl = ~clkb_tgl;
    if (rq_en && !pend && $urandom_range(0, 15) == 0) begin
      pend = 1;
      req_sel = 1'($urandom_range(0, 1));
    end
    req_valid = pend;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pend = 0;
    req_valid = 1'b0;
    m_reset();
    repeat (3) begin
      drive();
      step();
    end
    rst = 1'b0;
  endtask

  task automatic run(input int cyc);
    repeat (cyc) begin
      drive();
      step();
    end
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (!req_ready && k < 300) begin
      drive();
      step();
      k++;
    end
    if (k >= 300) chk(tag, 0, 1);
  endtask

  initial begin
    int t0, t_done, t_rdy, t_fall, t_fail, k;
    bit saw_err, saw_done, tgt;
    m_reset();
    a_run = 1; b_run = 1; rq_en = 0; pend = 0;
    @(negedge clk);
    do_reset();

    // switch to clkb: done at +SC, ready again at +SC+HC
    run(30);
    pend = 1; req_sel = 1'b1;
    drive();
    step();
    t0 = n;
    chk("t1_sel", int'(sel_clkb), 1);
    t_done = -1; t_rdy = -1; k = 0;
    while (t_rdy < 0 && k < 200) begin
      drive();
      step();
      if (done && t_done < 0) t_done = n - t0;
      if (req_ready) t_rdy = n - t0;
      k++;
    end
    chk("t1_done_lat", t_done, SC);
    chk("t1_ready_lat", t_rdy, SC + HC);

    // clkb dies with auto failover enabled
    auto_en = 1'b1; b_run = 0;
    t_fall = -1; t_fail = -1; k = 0;
    while (t_fail < 0 && k < 100) begin
      drive();
      step();
      if (!clkb_ok && t_fall < 0) t_fall = n;
      if (fail_irq) t_fail = n;
      k++;
    end
    chk("t2_fail_lat", t_fail - t_fall, 1);
    chk("t2_sel", int'(sel_clkb), 0);

    // request a dead clock
    wait_ready("t3_ready_timeout");
    pend = 1; req_sel = 1'b1;
    drive();
    step();
    chk("t3_err", int'(err), 1);
    chk("t3_sel", int'(sel_clkb), 0);
    chk("t3_busy", int'(busy), 0);

    // failover and request in the same cycle
    b_run = 1;
    run(10);
    a_run = 0;
    k = 0;
    while (clka_ok && k < 100) begin
      drive();
      step();
      k++;
    end
    pend = 1; req_sel = 1'b0;
    drive();
    #1 chk("t5_ready", int'(req_ready), 0);
    step();
    t0 = n;
    chk("t5_fail", int'(fail_irq), 1);
    t_rdy = -1; k = 0;
    while (t_rdy < 0 && k < 200) begin
      drive();
      step();
      if (m_acc) t_rdy = n - t0;
      k++;
    end
    chk("t5_acc_lat", t_rdy, SC + HC + 1);

    // target dies ten cycles into SETTLE, no failover
    auto_en = 1'b0; a_run = 1; b_run = 1;
    run(20);
    wait_ready("t4_ready_timeout");
    tgt = !sel_clkb;
    pend = 1; req_sel = tgt;
    drive();
    step();
    run(10);
    if (tgt) b_run = 0;
    else a_run = 0;
    saw_err = 0; saw_done = 0; k = 0;
    while (!saw_err && k < 60) begin
      drive();
      step();
      if (err) saw_err = 1;
      if (done) saw_done = 1;
      k++;
    end
    chk("t4_err", int'(saw_err), 1);
    chk("t4_no_done", int'(saw_done), 0);
    chk("t4_busy", int'(busy), 0);
    chk("t4_sel", int'(sel_clkb), int'(tgt));

    // async reset in the middle of SETTLE
    a_run = 1; b_run = 1;
    do_reset();
    run(30);
    pend = 1; req_sel = 1'b1;
    drive();
    step();
    run(10);
    chk("t6_pre_sel", int'(sel_clkb), 1);
    #2 rst = 1'b1;
    m_reset();
    pend = 0;
    req_valid = 1'b0;
    #1;
    chk("t6_sel", int'(sel_clkb), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_aok", int'(clka_ok), 0);
    chk("t6_bok", int'(clkb_ok), 0);
    @(negedge clk);
    run(2);
    rst = 1'b0;

    // random traffic
    rq_en = 1;
    for (int i = 0; i < 6000; i++) begin
      if (i % 150 == 0) begin
        a_run = ($urandom_range(0, 3) != 0);
        b_run = ($urandom_range(0, 3) != 0);
        auto_en = 1'($urandom_range(0, 1));
      end
      drive();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
